udp_eth_tx: RTL and testbench
=============================

Name: udp_eth_tx

Overview:
Ethernet/IPv4 frame transmitter, the send-side counterpart of the byte-stream frame receiver. It accepts a payload length and a byte-wide payload stream, and emits one complete frame byte by byte: preamble, SFD, destination MAC, source MAC, ethertype, payload, zero padding, then an inter-frame gap. It sits between the UDP/IP payload builder and the byte-wide PHY/loopback interface that feeds the receiver.

Parameters:
SRC_MAC, 48'h02_00_00_00_00_01, source MAC; sent MSB byte first
DST_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC; sent MSB byte first
ETHERTYPE, 16'h0800, ethertype; high byte first
MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded
MAX_PAYLOAD, 1500, maximum accepted payload_len
IFG_BYTES, 12, idle cycles after each frame

Ports:
main_clk  in  1  clock
main_rst  in  1  synchronous, active-high reset
start  in  1  frame request; sampled only in IDLE
payload_len  in  11  payload byte count; latched when start is accepted
pay_byte  in  8  payload data
pay_valid  in  1  payload byte available
pay_ready  out  1  payload byte consumed when pay_valid && pay_ready
eth_byte  out  8  frame byte to PHY
eth_valid  out  1  eth_byte valid
eth_ready  in  1  PHY accepts byte; a transfer occurs when eth_valid && eth_ready
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the last frame byte transfers
len_err  out  1  one-cycle pulse when start carries an illegal length

Behaviour:
- Clock and reset: one clock, main_clk. Reset is synchronous and active-high on main_rst.
- Reset values: state=IDLE; eth_valid, pay_ready, busy, frame_done, len_err all 0; eth_byte=8'h00; all counters 0.
- Reset mid-frame: the frame is abandoned. Outputs take their reset values on the next edge. No frame_done pulse is generated.
- States and contents:
  - IDLE
  - PREAMBLE: 7 bytes of 0x55
  - SFD: 0xD5
  - DST: 6 bytes
  - SRC: 6 bytes
  - TYPE: 2 bytes
  - PAYLOAD: payload_len bytes
  - PAD: MIN_PAYLOAD - payload_len bytes of 0x00, only when payload_len < MIN_PAYLOAD
  - [FCS]
  - IFG
- Start handling in IDLE:
  - If start=1 and 1 <= payload_len <= MAX_PAYLOAD: latch the length and go to PREAMBLE.
  - If start=1 with any other length: pulse len_err, stay in IDLE.
  - start is ignored in all other states.
- Latency: start accepted at edge N gives eth_valid=1 and eth_byte=0x55 after edge N+1 (registered output).
- Non-payload states (PREAMBLE through TYPE, PAD, FCS):
  - eth_valid=1, eth_byte is registered.
  - A byte counter advances only on a transfer.
  - While eth_ready=0, eth_byte holds stable.
- PAYLOAD state, combinational pass-through:
  - eth_byte=pay_byte, eth_valid=pay_valid, pay_ready=eth_ready.
  - The counter advances on pay_valid && eth_ready.
  - pay_ready is 0 in every other state.
- Stalls: a stall (eth_ready=0 or pay_valid=0) inserts no bytes and drops no bytes.
- State transition: taken on the transfer of the last byte of the current state.
- frame_done: asserted in the same cycle that IFG is entered.
- IFG state:
  - eth_valid=0.
  - Counts IFG_BYTES clocks unconditionally, ignoring eth_ready, then returns to IDLE.
  - start is honoured from the first IDLE cycle.
- Width rules: 11-bit counters. Pad length = MIN_PAYLOAD - payload_len, computed at latch time; no underflow because PAD is skipped when payload_len >= MIN_PAYLOAD.
- Frame size: total transferred bytes = 22 + max(payload_len, 46), plus 4 when FCS is enabled.

Optional Feature:
- Macro: UDP_ETH_TX_FCS_EN
- Defined:
  - FCS state follows PAD (or PAYLOAD when there is no PAD).
  - Sends the 4-byte IEEE 802.3 CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Coverage: bytes from the DST bytes through the PAD bytes.
  - Byte order: least significant byte first.
  - The CRC updates only on transfers, resets in IDLE, and is frozen while FCS bytes are sent.
- Undefined: no CRC logic; the frame ends after PAD or PAYLOAD.

Test Plan:
- Basic frame:
  - Stimulus: reset; start with payload_len=10, payload 0x01..0x0A, eth_ready=1, pay_valid=1.
  - Response: 68 transfers. Bytes 0..6 are 0x55, byte 7 is 0xD5, bytes 8..13 are 0xFF, bytes 14..19 are 02 00 00 00 00 01, bytes 20..21 are 08 00, bytes 22..31 are 01..0A, bytes 32..67 are 0x00.
  - frame_done pulses on the 68th transfer, followed by 12 cycles with eth_valid=0.
- No-pad frame:
  - Stimulus: payload_len=100.
  - Response: 122 transfers, no pad bytes, last byte equals payload byte 100.
- Backpressure:
  - Stimulus: payload_len=50; eth_ready toggles 1,0,0,1 repeatedly; pay_valid drops for 3 cycles mid-payload.
  - Response: the byte sequence matches the unstalled run, eth_byte is stable during stalls, and the total is 72 transfers.
- Length errors:
  - Stimulus: start with payload_len=0, then start with payload_len=1501.
  - Response: len_err pulses once for each; busy stays 0; eth_valid stays 0.
- Reset and start-while-busy:
  - Stimulus: main_rst asserted at payload byte 5; then start pulses while busy.
  - Response: after reset, eth_valid=0 and busy=0 on the next edge, no frame_done. A start pulse while busy is ignored, and the next accepted start restarts with 0x55.
- FCS (UDP_ETH_TX_FCS_EN defined):
  - Stimulus: payload_len=10 frame as in the basic frame case.
  - Response: 72 transfers. The last 4 bytes equal the bench's CRC-32 of bytes 8..67, LSB first.

Source files
------------

// File: rtl/udp_eth_tx.sv
// udp_eth_tx: byte-wide Ethernet frame transmitter.
// Sends preamble, SFD, destination MAC, source MAC, ethertype, payload,
// zero padding up to MIN_PAYLOAD, an optional FCS, and then an inter-frame gap.
//
// Optional feature macro: UDP_ETH_TX_FCS_EN
// When it is defined, a 4-byte IEEE 802.3 CRC-32 is appended (LSB first).
//
// Ports:
//   main_clk, main_rst     clock, synchronous active-high reset
//   start, payload_len     frame request and payload length (sampled in IDLE)
//   pay_byte/valid/ready   payload input stream
//   eth_byte/valid/ready   frame output stream to the PHY
//   busy                   high in every state except IDLE
//   frame_done             one-cycle pulse on the first IFG cycle
//   len_err                one-cycle pulse after a start with an illegal length
//
// Handshake: a byte moves on a clock edge where valid && ready. A valid
// producer holds its data until that edge. In PAYLOAD the payload stream
// passes straight through to the PHY side.
module udp_eth_tx #(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter logic [10:0] MIN_PAYLOAD = 11'd46,
  parameter logic [10:0] MAX_PAYLOAD = 11'd1500,
  parameter logic [10:0] IFG_BYTES   = 11'd12
) (
  input  logic        main_clk,
  input  logic        main_rst,
  input  logic        start,
  input  logic [10:0] payload_len,
  input  logic [7:0]  pay_byte,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [7:0]  eth_byte,
  output logic        eth_valid,
  input  logic        eth_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        len_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DST, S_SRC, S_TYPE,
    S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t      state, nxt_state;
  logic [10:0] cnt, nxt_cnt, len_q, pad_len_q;
  logic [7:0]  eth_byte_q, nxt_byte;
  logic        eth_valid_q, frame_done_q, len_err_q;
  logic        xfer, last;
  logic [47:0] mac_sh;
  state_t      tail_state;

  // PAYLOAD is a combinational pass-through; every other state drives registers.
  assign eth_byte   = (state == S_PAYLOAD) ? pay_byte  : eth_byte_q;
  assign eth_valid  = (state == S_PAYLOAD) ? pay_valid : eth_valid_q;
  assign pay_ready  = (state == S_PAYLOAD) && eth_ready;
  assign xfer       = eth_valid && eth_ready;
  assign busy       = (state != S_IDLE);
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;

`ifdef UDP_ETH_TX_FCS_EN
  assign tail_state = S_FCS;

  logic [31:0] crc_q, crc_nxt, fcs;
  logic        crc_en;

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Coverage runs from DST through PAD; the value is frozen during FCS.
  assign crc_en  = xfer && (state inside {S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_PAD});
  assign crc_nxt = crc_en ? crc_step(crc_q, eth_byte) : crc_q;
  assign fcs     = ~crc_nxt;

  always_ff @(posedge main_clk) begin
    if (main_rst || state == S_IDLE) crc_q <= 32'hFFFF_FFFF;
    else                             crc_q <= crc_nxt;
  end
`else
  assign tail_state = S_IFG;
`endif

  // Is the byte currently on offer the last one of its state?
  always_comb begin
    last = 1'b0;
    case (state)
      S_PREAMBLE: last = (cnt == 11'd6);
      S_SFD:      last = 1'b1;
      S_DST:      last = (cnt == 11'd5);
      S_SRC:      last = (cnt == 11'd5);
      S_TYPE:     last = (cnt == 11'd1);
      S_PAYLOAD:  last = (cnt == len_q - 11'd1);
      S_PAD:      last = (cnt == pad_len_q - 11'd1);
      S_FCS:      last = (cnt == 11'd3);
      default:    last = 1'b0;
    endcase
  end

  // Position after the current byte transfers.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = last ? 11'd0 : cnt + 11'd1;
    if (last) begin
      case (state)
        S_PREAMBLE: nxt_state = S_SFD;
        S_SFD:      nxt_state = S_DST;
        S_DST:      nxt_state = S_SRC;
        S_SRC:      nxt_state = S_TYPE;
        S_TYPE:     nxt_state = S_PAYLOAD;
        S_PAYLOAD:  nxt_state = (len_q < MIN_PAYLOAD) ? S_PAD : tail_state;
        S_PAD:      nxt_state = tail_state;
        S_FCS:      nxt_state = S_IFG;
        default:    nxt_state = state;
      endcase
    end
  end

  // Byte to register for the next position (MACs go out MSB byte first).
  always_comb begin
    nxt_byte = 8'h00;
    mac_sh   = 48'h0;
    case (nxt_state)
      S_PREAMBLE: nxt_byte = 8'h55;
      S_SFD:      nxt_byte = 8'hD5;
      S_DST: begin
        mac_sh   = DST_MAC << {nxt_cnt[2:0], 3'b000};
        nxt_byte = mac_sh[47:40];
      end
      S_SRC: begin
        mac_sh   = SRC_MAC << {nxt_cnt[2:0], 3'b000};
        nxt_byte = mac_sh[47:40];
      end
      S_TYPE:     nxt_byte = nxt_cnt[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
`ifdef UDP_ETH_TX_FCS_EN
      S_FCS: begin
        mac_sh   = {16'h0, fcs >> {nxt_cnt[1:0], 3'b000}};
        nxt_byte = mac_sh[7:0];
      end
`endif
      default:    nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      state        <= S_IDLE;
      cnt          <= 11'd0;
      len_q        <= 11'd0;
      pad_len_q    <= 11'd0;
      eth_byte_q   <= 8'h00;
      eth_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (payload_len != 11'd0 && payload_len <= MAX_PAYLOAD) begin
              state     <= S_PREAMBLE;
              cnt       <= 11'd0;
              len_q     <= payload_len;
              pad_len_q <= MIN_PAYLOAD - payload_len;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        S_IFG: begin
          // Gap runs on clocks alone; eth_ready plays no part.
          if (cnt == IFG_BYTES - 11'd1) begin
            state <= S_IDLE;
            cnt   <= 11'd0;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        default: begin
          if (state != S_PAYLOAD && !eth_valid_q) begin
            // First PREAMBLE cycle: load the first registered byte.
            eth_valid_q <= 1'b1;
            eth_byte_q  <= 8'h55;
          end else if (xfer) begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            eth_byte_q  <= nxt_byte;
            eth_valid_q <= (nxt_state != S_PAYLOAD) && (nxt_state != S_IFG);
            if (nxt_state == S_IFG) frame_done_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_eth_tx.sv
// Testbench for udp_eth_tx: directed frames checked against a byte-level
// expected queue built from the frame layout.
module tb_udp_eth_tx;

  logic        main_clk = 1'b0;
  logic        main_rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] payload_len = 11'd0;
  logic [7:0]  pay_byte = 8'h00;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [7:0]  eth_byte;
  logic        eth_valid;
  logic        eth_ready = 1'b1;
  logic        busy, frame_done, len_err;

  udp_eth_tx dut (
    .main_clk    (main_clk),
    .main_rst    (main_rst),
    .start       (start),
    .payload_len (payload_len),
    .pay_byte    (pay_byte),
    .pay_valid   (pay_valid),
    .pay_ready   (pay_ready),
    .eth_byte    (eth_byte),
    .eth_valid   (eth_valid),
    .eth_ready   (eth_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .len_err     (len_err)
  );

  // ---------------- clock / reset ----------------
  always #5 main_clk = ~main_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected frame: header, payload (i+1), zero pad, optional CRC-32 LSB first.
  task automatic build_frame(input int len);
    logic [47:0] src;
    logic [31:0] crc;
    logic [7:0]  b;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'hFF);
    src = 48'h02_00_00_00_00_01;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(src[47:40]);
      src = src << 8;
    end
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h00);
    for (int i = 0; i < len; i++) exp_q.push_back(8'(i + 1));
    for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
`ifdef UDP_ETH_TX_FCS_EN
    crc = 32'hFFFF_FFFF;
    for (int k = 8; k < exp_q.size(); k++) begin
      b = exp_q[k];
      for (int j = 0; j < 8; j++) begin
        if (crc[0] ^ b[j]) crc = (crc >> 1) ^ 32'hEDB88320;
        else               crc = crc >> 1;
      end
    end
    crc = ~crc;
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(crc[7:0]);
      crc = crc >> 8;
    end
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Invariant: tasks are entered and left 1 time unit after a rising edge.
  // bp: eth_ready pattern 1,0,0,1 and a 3-cycle pay_valid gap at payload byte 20.
  // abort_at >= 0: assert reset once that many payload bytes have been consumed.
  // busy_start >= 0: pulse start on that cycle of the frame.
  task automatic run_frame(input int len, input bit bp, input int abort_at, input int busy_start);
    int total, nx, pidx, post, pv_gap, fd_extra, ifg_valid, fdc;
    bit done, gap_done, prev_stall;
    logic [7:0] prev_byte;
    nx = 0; pidx = 0; post = 0; pv_gap = 0; fd_extra = 0; ifg_valid = 0; fdc = 0;
    done = 1'b0; gap_done = 1'b0; prev_stall = 1'b0; prev_byte = 8'h00;
    build_frame(len);
    total = exp_q.size();
    start = 1'b1;
    payload_len = 11'(len);
    @(posedge main_clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (abort_at >= 0 && pidx == abort_at) begin
        main_rst = 1'b1;
        @(posedge main_clk); #1;
        main_rst = 1'b0;
        check("rst_valid", eth_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_byte", eth_byte, 0);
        check("rst_done", frame_done, 0);
        repeat (15) begin
          @(posedge main_clk); #1;
          fdc += frame_done;
        end
        check("rst_no_done_later", fdc, 0);
        exp_q.delete();
        return;
      end
      eth_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (bp && pidx == 20 && !gap_done) begin
        pv_gap = 3;
        gap_done = 1'b1;
      end
      if (pv_gap > 0) begin
        pay_valid = 1'b0;
        pv_gap--;
      end else begin
        pay_valid = 1'b1;
      end
      pay_byte = (pidx < len) ? 8'(pidx + 1) : 8'h00;
      start = (cyc == busy_start);
      payload_len = (cyc == busy_start) ? 11'd20 : 11'(len);
      #1;
      if (cyc == 0) check("start_bubble", {busy, eth_valid}, 2'b10);
      if (prev_stall && eth_valid) check("stall_hold", eth_byte, prev_byte);
      prev_stall = eth_valid && !eth_ready;
      prev_byte = eth_byte;
      if (nx == total) begin
        if (busy) begin
          if (post == 0) check("frame_done", frame_done, 1);
          else if (frame_done) fd_extra++;
          if (eth_valid) ifg_valid++;
          post++;
        end else begin
          done = 1'b1;
        end
      end else if (frame_done) begin
        fd_extra++;
      end
      if (!done && eth_valid && eth_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 1, 0);
        else check("byte", eth_byte, exp_q.pop_front());
        nx++;
        if (pay_valid && pay_ready) pidx++;
      end
      if (!done) begin
        @(posedge main_clk); #1;
      end
    end
    start = 1'b0;
    check("timeout", done, 1);
    check("xfer_count", nx, total);
    check("ifg_cycles", post, 12);
    check("done_pulses_extra", fd_extra, 0);
    check("ifg_valid", ifg_valid, 0);
    @(posedge main_clk); #1;
  endtask

  task automatic len_err_test(input logic [10:0] len);
    start = 1'b1;
    payload_len = len;
    @(posedge main_clk); #1;
    start = 1'b0;
    check("len_err_pulse", len_err, 1);
    check("len_err_busy", busy, 0);
    check("len_err_valid", eth_valid, 0);
    @(posedge main_clk); #1;
    check("len_err_clear", len_err, 0);
    check("len_err_busy2", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    main_rst = 1'b1;
    repeat (3) @(posedge main_clk);
    #1;
    check("reset_valid", eth_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_pay_ready", pay_ready, 0);
    check("reset_done", frame_done, 0);
    check("reset_len_err", len_err, 0);
    check("reset_byte", eth_byte, 0);
    main_rst = 1'b0;
    pay_valid = 1'b1;
    @(posedge main_clk); #1;

    run_frame(10, 1'b0, -1, -1);   // basic frame, padded
    run_frame(100, 1'b0, -1, -1);  // no pad
    run_frame(50, 1'b1, -1, -1);   // backpressure and payload gap
    len_err_test(11'd0);
    len_err_test(11'd1501);
    run_frame(10, 1'b0, 5, -1);    // reset mid-payload
    run_frame(20, 1'b0, -1, 30);   // start while busy is ignored
    run_frame(10, 1'b0, -1, -1);   // next frame starts cleanly
    run_frame(1, 1'b0, -1, -1);    // shortest legal payload

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
